// File: rtl/instruction_memory_ld_if.sv
// instruction_memory_ld_if
// Bundles the fetch port and the byte-stream loader port of the
// instruction memory.
//   master : the PC/decode side plus boot loader (drives requests and bytes)
//   slave  : the memory itself (drives fetch responses and loader status)
// Parameters must match the ones used on instruction_memory_ld.
interface instruction_memory_ld_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
);
    localparam int IDX_W = $clog2(DEPTH);

    // fetch port
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              misaligned;
    logic              parity_err;

    // loader port
    logic              load_start;
    logic [IDX_W:0]    load_words;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              loading;
    logic              load_done;

    modport master (
        output fetch_req, fetch_addr, load_start, load_words, load_valid, load_byte,
        input  instruction, instr_valid, misaligned, parity_err,
               load_ready, loading, load_done
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_words, load_valid, load_byte,
        output instruction, instr_valid, misaligned, parity_err,
               load_ready, loading, load_done
    );
endinterface

// File: rtl/instruction_memory_ld.sv
// instruction_memory_ld
// Synchronous-read instruction memory with a built-in byte-stream boot loader.
// Fetches return one word one cycle after the request; misaligned PCs return
// a NOP with `misaligned` set. The loader fills words from index 0 upward,
// most significant byte first; fetches are not served while a load runs.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : instruction_memory_ld_if.slave (fetch + loader signals)
//
// Optional build macro IMEM_PARITY_EN: stores an even-parity bit per word and
// reports a mismatch on `parity_err` for served aligned fetches. Without it,
// `parity_err` is tied low.
//
// Loader FSM
//   state  | meaning
//   S_IDLE | no load; fetches served; load_start accepted
//   S_LOAD | accepting bytes (loading=1, load_ready=1); fetches stalled
//   S_DONE | final word written; load_done=1 for this one cycle
module instruction_memory_ld #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    instruction_memory_ld_if.slave  bus
);
    localparam int             IDX_W   = $clog2(DEPTH);
    localparam int             BYTES   = DATA_W / 8;
    localparam int             CNT_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] asm_reg;
    logic [DATA_W-1:0] next_word;
    logic [CNT_W-1:0]  byte_cnt;
    logic [IDX_W-1:0]  word_ptr;
    logic [IDX_W:0]    target;
    logic              last_byte;
    logic              word_wr;
    logic              target_hit;
    logic [IDX_W-1:0]  fetch_idx;
    logic              fetch_par_err;
    logic              unused_addr_hi;

    // New byte enters at the bottom; the oldest byte ends up most significant.
    assign next_word  = DATA_W'({asm_reg, bus.load_byte});
    assign last_byte  = (byte_cnt == CNT_W'(BYTES - 1));
    assign word_wr    = (state == S_LOAD) && bus.load_valid && last_byte;
    // Compare the count of words written including the one going in now.
    assign target_hit = (({1'b0, word_ptr} + (IDX_W + 1)'(1)) == target);

    // Upper PC bits do not select anything; the array wraps modulo DEPTH*4.
    assign fetch_idx      = bus.fetch_addr[IDX_W+1:2];
    assign unused_addr_hi = ^bus.fetch_addr[ADDR_W-1:IDX_W+2];

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[word_ptr] <= next_word;
        end
    end

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem_par[word_ptr] <= ^next_word;
        end
    end

    assign fetch_par_err = (^mem[fetch_idx]) != mem_par[fetch_idx];
`else
    assign fetch_par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            asm_reg         <= '0;
            byte_cnt        <= '0;
            word_ptr        <= '0;
            target          <= '0;
            bus.load_ready  <= 1'b0;
            bus.loading     <= 1'b0;
            bus.load_done   <= 1'b0;
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            bus.misaligned  <= 1'b0;
            bus.parity_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load_start) begin
                        state          <= S_LOAD;
                        byte_cnt       <= '0;
                        word_ptr       <= '0;
                        bus.loading    <= 1'b1;
                        bus.load_ready <= 1'b1;
                        // 0 and anything beyond the array both mean "fill it all".
                        if (bus.load_words == '0 || bus.load_words > DEPTH_W) begin
                            target <= DEPTH_W;
                        end else begin
                            target <= bus.load_words;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.load_valid) begin
                        asm_reg <= next_word;
                        if (last_byte) begin
                            byte_cnt <= '0;
                            word_ptr <= word_ptr + IDX_W'(1);
                            if (target_hit) begin
                                state          <= S_DONE;
                                bus.loading    <= 1'b0;
                                bus.load_ready <= 1'b0;
                                bus.load_done  <= 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    bus.load_done <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Fetch response: a stalled fetch returns a zero word so the core
            // never sees stale data alongside instr_valid=0; an idle cycle
            // leaves the last word in place.
            if (bus.fetch_req && state != S_LOAD) begin
                bus.instr_valid <= 1'b1;
                if (bus.fetch_addr[1:0] != 2'b00) begin
                    bus.instruction <= '0;
                    bus.misaligned  <= 1'b1;
                    bus.parity_err  <= 1'b0;
                end else begin
                    bus.instruction <= mem[fetch_idx];
                    bus.misaligned  <= 1'b0;
                    bus.parity_err  <= fetch_par_err;
                end
            end else begin
                if (bus.fetch_req) begin
                    bus.instruction <= '0;
                end
                bus.instr_valid <= 1'b0;
                bus.misaligned  <= 1'b0;
                bus.parity_err  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/instruction_memory_ld.md
# instruction_memory_ld

Parametrised, synchronous-read instruction memory for the MIPS core, with a built-in byte-stream boot loader. The fetch port returns one word per request with one-cycle latency and flags misaligned PCs. The loader port fills the array from address 0 upward, four bytes per word, most significant byte first. While a load is in progress, fetches are stalled. The block sits between the PC register and the decode stage and replaces hard-coded program images.

## Interface
- DATA_W, 32, instruction word width; multiple of 8.
- DEPTH, 64, number of words; power of two, at least 2.
- ADDR_W, 32, byte-address width of `fetch_addr`.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- fetch_req  in  1  fetch strobe for `fetch_addr`.
- fetch_addr  in  ADDR_W  byte address (PC).
- instruction  out  DATA_W  registered fetched word.
- instr_valid  out  1  `instruction` is valid this cycle.
- misaligned  out  1  the fetch that produced this cycle's response had `fetch_addr[1:0]` != 0.
- parity_err  out  1  stored parity mismatch on this cycle's response.
- load_start  in  1  begins a load; sampled in IDLE only.
- load_words  in  IDX_W+1  number of words to load; 0 means DEPTH; values above DEPTH are clamped to DEPTH.
- load_valid  in  1  `load_byte` is valid.
- load_byte  in  8  loader data byte.
- load_ready  out  1  block accepts a byte this cycle.
- loading  out  1  a load is in progress.
- load_done  out  1  one-cycle pulse after the final word is written.

## Operation
- FSM states:
  - IDLE: `load_ready`=0.
  - LOAD: `loading`=1 and `load_ready`=1.
  - DONE: lasts one cycle; `load_done`=1; returns to IDLE.
- IDLE→LOAD on `load_start`=1. This latches the word target and clears the byte counter (2 bits) and the word pointer (IDX_W bits).
- In LOAD, each cycle with `load_valid`=1 is one byte transfer.
  - Bytes shift into a DATA_W assembly register, MSB first.
  - On the (DATA_W/8)th byte, the assembled word (the final byte included) is written to `mem[word_ptr]`.
  - After the write, `word_ptr` increments and the byte counter clears.
- When the written-word count equals the target, LOAD→DONE on that same edge.
- `load_start` is ignored outside IDLE.
- Fetch in IDLE or DONE:
  - Index = `fetch_addr[IDX_W+1:2]`; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
  - The response appears on the next cycle with `instr_valid`=1.
  - If `fetch_addr[1:0]` != 0: response `instruction`=0 (NOP), `misaligned`=1, `instr_valid`=1.
- Fetch in LOAD: not served; `instr_valid`=0 and `instruction`=0 on the next cycle. The core treats `!instr_valid` as a stall.
- `fetch_req`=0: `instr_valid`=0 next cycle; `instruction` holds its previous value.
- `load_start` and `fetch_req` in the same IDLE cycle: the fetch is served normally.
- The memory array is not reset. Contents are undefined until loaded, or until an initial image is provided.

## Timing
- Reset values: `instruction`=0, `instr_valid`=0, `misaligned`=0, `parity_err`=0, `load_ready`=0, `loading`=0, `load_done`=0, FSM=IDLE.
- Fetch latency: exactly 1 cycle; throughput one fetch per cycle.
- Load throughput: one byte per cycle. `load_ready` does not drop mid-load.
- Load of N words with continuous `load_valid`: `load_done` pulses 4N+1 cycles after the `load_start` cycle.
- Reset asserted mid-load:
  - FSM returns to IDLE immediately and the partial word is discarded.
  - Words already written are retained.
  - No `load_done` pulse.
- Gaps in `load_valid` stall the byte counter. There is no timeout.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed at write.
  - On a served aligned fetch, `parity_err`=1 alongside the response if the recomputed parity mismatches.
- IMEM_PARITY_EN undefined: no parity storage; `parity_err` is tied to 0. The port is present in both builds.

## Test plan
- Reset mid-stream: reset after 2 bytes of word 0 → `loading`=0, `load_ready`=0, all outputs 0; a fresh load of 1 word, 0x20090005, then fetch 0x0 → 0x20090005.
- Load 3 words 0x2149_0005, 0xAD29_0000, 0x8D2B_0000 with continuous valid → `load_done` at cycle 13; fetches 0x0/0x4/0x8 return those words, each 1 cycle later with `instr_valid`=1.
- Fetch 0x6 → next cycle `instruction`=0, `misaligned`=1, `instr_valid`=1; fetch 0x100 with DEPTH=64 wraps to word 0.
- Fetch during LOAD → `instr_valid`=0 every cycle; `load_valid` toggling 1/0 → `load_done` delayed to cycle 25 for 3 words; `load_words`=0 loads 64 words.
- `load_start` asserted during LOAD → ignored; the word count is unchanged.
- IMEM_PARITY_EN build: force-flip one stored bit via hierarchical access, fetch that word → `parity_err`=1; an unflipped word → 0. Non-parity build: always 0.
